// File: rtl/spi_pkg.sv
// spi_pkg: SPI target mode constants and edge helpers.
// Shared by spi_target and its FIFO sub-module.
package spi_pkg;

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  localparam int CPOL_BIT = 1;
  localparam int CPHA_BIT = 0;

  typedef enum logic {
    IDLE,
    XFER
  } state_t;

  function automatic logic sample_on_rise(input logic [1:0] m);
    return m[CPOL_BIT] == m[CPHA_BIT];
  endfunction

endpackage

// File: rtl/spi_target_sync_fifo.sv
// sync_fifo: single-clock FIFO, power-of-two depth.
// Push into a full FIFO is accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rptr];

  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      if (do_push & ~do_pop)
        level <= level + (AW+1)'(1);
      else if (do_pop & ~do_push)
        level <= level - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_data;
  end

endmodule

// File: rtl/spi_target.sv
// spi_target: SPI target with RX/TX FIFOs and sticky error flags.
// Pins are synchronised; all serial decisions run on clk.
module spi_target
  import spi_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             mode,
  input  logic                   sck,
  input  logic                   ssn,
  input  logic                   si,
  output logic                   so,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  input  logic [WIDTH-1:0]       tx_data,
  output logic                   rx_valid,
  input  logic                   rx_ready,
  output logic [WIDTH-1:0]       rx_data,
  output logic                   overrun,
  output logic                   underrun,
  input  logic                   clr,
  output logic [$clog2(DEPTH):0] rx_level,
  output logic [$clog2(DEPTH):0] tx_level
);

  localparam int CW = $clog2(WIDTH);

  state_t           state;
  logic [1:0]       mode_q;
  logic [2:0]       sck_q;
  logic [2:0]       ssn_q;
  logic [1:0]       si_q;
  logic [CW-1:0]    cnt;
  logic             loaded;
  logic [WIDTH-1:0] rx_sr;
  logic [WIDTH-1:0] tx_sr;
  logic [WIDTH-1:0] rx_word;
  logic             done_q;

  logic             rise, fall, start, stop;
  logic             sample_edge, shift_edge;
  logic             load, tx_pop, rx_pop;
  logic             tx_full, tx_empty, rx_full, rx_empty;
  logic [WIDTH-1:0] tx_head, load_word;

  assign rise  = sck_q[1] & ~sck_q[2];
  assign fall  = ~sck_q[1] & sck_q[2];
  assign start = ssn_q[2] & ~ssn_q[1];
  assign stop  = ~ssn_q[2] & ssn_q[1];

  assign sample_edge = (state == XFER) &
    (sample_on_rise(mode_q) ? rise : fall);
  assign shift_edge = (state == XFER) &
    (sample_on_rise(mode_q) ? fall : rise);

  // CPHA=0 loads the first word as the frame opens
  assign load = (start & ~mode[CPHA_BIT]) |
    (shift_edge & ~loaded & ~stop);
  assign tx_pop    = load & ~tx_empty;
  assign load_word = tx_empty ? '0 : tx_head;

  assign rx_valid = ~rx_empty;
  assign tx_ready = ~tx_full;
  assign rx_pop   = rx_valid & rx_ready;
  assign so       = (state == XFER) & tx_sr[WIDTH-1];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      mode_q   <= MODE0;
      sck_q    <= '1;
      ssn_q    <= '1;
      si_q     <= '1;
      cnt      <= '0;
      loaded   <= 1'b0;
      rx_sr    <= '0;
      tx_sr    <= '0;
      rx_word  <= '0;
      done_q   <= 1'b0;
      overrun  <= 1'b0;
      underrun <= 1'b0;
    end else begin
      sck_q  <= {sck_q[1:0], sck};
      ssn_q  <= {ssn_q[1:0], ssn};
      si_q   <= {si_q[0], si};
      done_q <= 1'b0;
      if (stop) begin
        state  <= IDLE;
        cnt    <= '0;
        loaded <= 1'b0;
        rx_sr  <= '0;
        tx_sr  <= '0;
      end else if (start) begin
        state  <= XFER;
        mode_q <= mode;
        cnt    <= '0;
        loaded <= ~mode[CPHA_BIT];
        rx_sr  <= '0;
        tx_sr  <= mode[CPHA_BIT] ? '0 : load_word;
      end else begin
        if (sample_edge) begin
          rx_sr <= {rx_sr[WIDTH-2:0], si_q[1]};
          if (cnt == CW'(WIDTH - 1)) begin
            cnt     <= '0;
            loaded  <= 1'b0;
            done_q  <= 1'b1;
            rx_word <= {rx_sr[WIDTH-2:0], si_q[1]};
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        if (shift_edge) begin
          if (!loaded) begin
            tx_sr  <= load_word;
            loaded <= 1'b1;
          end else begin
            tx_sr <= {tx_sr[WIDTH-2:0], 1'b0};
          end
        end
      end
      overrun  <= (done_q & rx_full & ~rx_pop) |
                  (overrun & ~clr);
      underrun <= (load & tx_empty) |
                  (underrun & ~clr);
    end
  end

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rx (
    .clk       (clk),
    .reset     (reset),
    .push      (done_q),
    .push_data (rx_word),
    .pop       (rx_pop),
    .head      (rx_data),
    .full      (rx_full),
    .empty     (rx_empty),
    .level     (rx_level)
  );

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_tx (
    .clk       (clk),
    .reset     (reset),
    .push      (tx_valid & tx_ready),
    .push_data (tx_data),
    .pop       (tx_pop),
    .head      (tx_head),
    .full      (tx_full),
    .empty     (tx_empty),
    .level     (tx_level)
  );

endmodule

// File: tb/tb_spi_target.sv
// tb_spi_target: directed checks on an 8-bit and a 16-bit target.
// The host drives shared pins; sel16 picks which target sees ssn.
module tb_spi_target;

  localparam int H = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [1:0] mode = 2'b00;
  logic sck = 1'b0;
  logic ssn = 1'b1;
  logic si = 1'b0;
  logic clr = 1'b0;
  logic sel16 = 1'b0;
  logic pop_on_push = 1'b0;
  logic rv_early;
  logic ssn8, ssn16, so_sel;

  logic so8, tx_valid8, tx_ready8, rx_valid8, rx_ready8;
  logic [7:0] tx_data8, rx_data8;
  logic overrun8, underrun8;
  logic [2:0] rx_level8, tx_level8;

  logic so16, tx_valid16, tx_ready16, rx_valid16, rx_ready16;
  logic [15:0] tx_data16, rx_data16;
  logic overrun16, underrun16;
  logic [2:0] rx_level16, tx_level16;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign ssn8   = ssn | sel16;
  assign ssn16  = ssn | ~sel16;
  assign so_sel = sel16 ? so16 : so8;

  spi_target #(.WIDTH(8), .DEPTH(4)) dut8 (
    .clk(clk), .reset(reset), .mode(mode),
    .sck(sck), .ssn(ssn8), .si(si), .so(so8),
    .tx_valid(tx_valid8), .tx_ready(tx_ready8),
    .tx_data(tx_data8),
    .rx_valid(rx_valid8), .rx_ready(rx_ready8),
    .rx_data(rx_data8),
    .overrun(overrun8), .underrun(underrun8),
    .clr(clr),
    .rx_level(rx_level8), .tx_level(tx_level8)
  );

  spi_target #(.WIDTH(16), .DEPTH(4)) dut16 (
    .clk(clk), .reset(reset), .mode(mode),
    .sck(sck), .ssn(ssn16), .si(si), .so(so16),
    .tx_valid(tx_valid16), .tx_ready(tx_ready16),
    .tx_data(tx_data16),
    .rx_valid(rx_valid16), .rx_ready(rx_ready16),
    .rx_data(rx_data16),
    .overrun(overrun16), .underrun(underrun16),
    .clr(clr),
    .rx_level(rx_level16), .tx_level(tx_level16)
  );

  task automatic push8(input logic [7:0] w);
    tx_data8 = w;
    tx_valid8 = 1'b1;
    @(negedge clk);
    tx_valid8 = 1'b0;
  endtask

  task automatic push16(input logic [15:0] w);
    tx_data16 = w;
    tx_valid16 = 1'b1;
    @(negedge clk);
    tx_valid16 = 1'b0;
  endtask

  task automatic pop8(output logic [7:0] d);
    d = rx_data8;
    rx_ready8 = 1'b1;
    @(negedge clk);
    rx_ready8 = 1'b0;
  endtask

  task automatic pop16(output logic [15:0] d);
    d = rx_data16;
    rx_ready16 = 1'b1;
    @(negedge clk);
    rx_ready16 = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic frame_begin();
    ssn = 1'b0;
    repeat (H) @(negedge clk);
  endtask

  task automatic frame_end();
    repeat (2) @(negedge clk);
    ssn = 1'b1;
    repeat (H) @(negedge clk);
  endtask

  // Host side: so is captured just before the host's sample edge
  task automatic xfer(input logic [31:0] w, input int n,
                      output logic [31:0] got);
    logic cpol, cpha;
    cpol = mode[1];
    cpha = mode[0];
    got = '0;
    for (int i = n - 1; i >= 0; i--) begin
      if (!cpha) begin
        si = w[i];
        repeat (H) @(negedge clk);
        got = {got[30:0], so_sel};
        sck = ~cpol;
        repeat (3) @(negedge clk);
        if (pop_on_push && i == 0) rx_ready8 = 1'b1;
        @(negedge clk);
        rx_ready8 = 1'b0;
        rv_early = sel16 ? rx_valid16 : rx_valid8;
        repeat (H - 4) @(negedge clk);
        sck = cpol;
      end else begin
        sck = ~cpol;
        si = w[i];
        repeat (H) @(negedge clk);
        got = {got[30:0], so_sel};
        sck = cpol;
        repeat (H) @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    repeat (5) @(negedge clk);
    n_cmp++;
    if (rx_valid8 !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_rx_valid: got %b want 0", rx_valid8);
    end
    n_cmp++;
    if (tx_ready8 !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_tx_ready: got %b want 1", tx_ready8);
    end
    n_cmp++;
    if (so8 !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_so: got %b want 0", so8);
    end
    n_cmp++;
    if ({overrun8, underrun8} !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 00",
               {overrun8, underrun8});
    end
    n_cmp++;
    if ({rx_level8, tx_level8} !== 6'd0) begin
      n_bad++;
      $display("FAIL reset_levels: got %0d/%0d want 0/0",
               rx_level8, tx_level8);
    end
    n_cmp++;
    if (tx_ready16 !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_tx_ready16: got %b want 1", tx_ready16);
    end
    reset = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_mode0();
    logic [31:0] got;
    logic [7:0] d;
    mode = 2'b00;
    sck = 1'b0;
    push8(8'hA5);
    n_cmp++;
    if (tx_level8 !== 3'd1) begin
      n_bad++;
      $display("FAIL m0_tx_level: got %0d want 1", tx_level8);
    end
    frame_begin();
    xfer(32'h3C, 8, got);
    n_cmp++;
    if (rv_early !== 1'b1) begin
      n_bad++;
      $display("FAIL m0_rx_valid_4clk: got %b want 1", rv_early);
    end
    frame_end();
    n_cmp++;
    if (got[7:0] !== 8'hA5) begin
      n_bad++;
      $display("FAIL m0_so: got %h want a5", got[7:0]);
    end
    n_cmp++;
    if (rx_level8 !== 3'd1) begin
      n_bad++;
      $display("FAIL m0_rx_level: got %0d want 1", rx_level8);
    end
    pop8(d);
    n_cmp++;
    if (d !== 8'h3C) begin
      n_bad++;
      $display("FAIL m0_rx_data: got %h want 3c", d);
    end
    n_cmp++;
    if (rx_valid8 !== 1'b0) begin
      n_bad++;
      $display("FAIL m0_drained: got %b want 0", rx_valid8);
    end
    pulse_clr();
  endtask

  task automatic test_back_to_back();
    logic [31:0] g1, g2;
    logic [15:0] d;
    sel16 = 1'b1;
    mode = 2'b11;
    sck = 1'b1;
    push16(16'h0F0F);
    push16(16'hF0F0);
    repeat (4) @(negedge clk);
    frame_begin();
    xfer(32'h1234, 16, g1);
    xfer(32'hABCD, 16, g2);
    frame_end();
    n_cmp++;
    if (g1[15:0] !== 16'h0F0F) begin
      n_bad++;
      $display("FAIL b2b_so0: got %h want 0f0f", g1[15:0]);
    end
    n_cmp++;
    if (g2[15:0] !== 16'hF0F0) begin
      n_bad++;
      $display("FAIL b2b_so1: got %h want f0f0", g2[15:0]);
    end
    n_cmp++;
    if (rx_level16 !== 3'd2) begin
      n_bad++;
      $display("FAIL b2b_rx_level: got %0d want 2", rx_level16);
    end
    pop16(d);
    n_cmp++;
    if (d !== 16'h1234) begin
      n_bad++;
      $display("FAIL b2b_rx0: got %h want 1234", d);
    end
    pop16(d);
    n_cmp++;
    if (d !== 16'hABCD) begin
      n_bad++;
      $display("FAIL b2b_rx1: got %h want abcd", d);
    end
    n_cmp++;
    if ({overrun16, underrun16} !== 2'b00) begin
      n_bad++;
      $display("FAIL b2b_flags: got %b want 00",
               {overrun16, underrun16});
    end
    n_cmp++;
    if (tx_level16 !== 3'd0) begin
      n_bad++;
      $display("FAIL b2b_tx_level: got %0d want 0", tx_level16);
    end
    sel16 = 1'b0;
  endtask

  task automatic test_overrun();
    logic [31:0] got;
    logic [7:0] d;
    mode = 2'b00;
    sck = 1'b0;
    repeat (4) @(negedge clk);
    frame_begin();
    for (int k = 1; k <= 5; k++)
      xfer(32'h11 * k, 8, got);
    frame_end();
    n_cmp++;
    if (rx_level8 !== 3'd4) begin
      n_bad++;
      $display("FAIL ovr_rx_level: got %0d want 4", rx_level8);
    end
    n_cmp++;
    if (overrun8 !== 1'b1) begin
      n_bad++;
      $display("FAIL ovr_flag: got %b want 1", overrun8);
    end
    pulse_clr();
    n_cmp++;
    if (overrun8 !== 1'b0) begin
      n_bad++;
      $display("FAIL ovr_clr: got %b want 0", overrun8);
    end
    for (int k = 1; k <= 4; k++) begin
      pop8(d);
      n_cmp++;
      if (d !== 8'(8'h11 * k)) begin
        n_bad++;
        $display("FAIL ovr_data%0d: got %h want %h",
                 k, d, 8'(8'h11 * k));
      end
    end
  endtask

  task automatic test_underrun();
    logic [31:0] got;
    logic [7:0] d;
    mode = 2'b01;
    sck = 1'b0;
    pulse_clr();
    n_cmp++;
    if (underrun8 !== 1'b0) begin
      n_bad++;
      $display("FAIL und_pre: got %b want 0", underrun8);
    end
    frame_begin();
    xfer(32'h5A, 8, got);
    frame_end();
    n_cmp++;
    if (got[7:0] !== 8'h00) begin
      n_bad++;
      $display("FAIL und_so: got %h want 00", got[7:0]);
    end
    n_cmp++;
    if (underrun8 !== 1'b1) begin
      n_bad++;
      $display("FAIL und_flag: got %b want 1", underrun8);
    end
    n_cmp++;
    if (tx_level8 !== 3'd0) begin
      n_bad++;
      $display("FAIL und_tx_level: got %0d want 0", tx_level8);
    end
    pop8(d);
    n_cmp++;
    if (d !== 8'h5A) begin
      n_bad++;
      $display("FAIL und_rx: got %h want 5a", d);
    end
  endtask

  task automatic test_abort();
    logic [31:0] got;
    logic [7:0] d;
    mode = 2'b00;
    sck = 1'b0;
    repeat (4) @(negedge clk);
    frame_begin();
    xfer(32'h1F, 5, got);
    frame_end();
    n_cmp++;
    if (rx_level8 !== 3'd0) begin
      n_bad++;
      $display("FAIL abort_partial: got %0d want 0", rx_level8);
    end
    frame_begin();
    xfer(32'h81, 8, got);
    frame_end();
    n_cmp++;
    if (rx_level8 !== 3'd1) begin
      n_bad++;
      $display("FAIL abort_rx_level: got %0d want 1", rx_level8);
    end
    pop8(d);
    n_cmp++;
    if (d !== 8'h81) begin
      n_bad++;
      $display("FAIL abort_rx: got %h want 81", d);
    end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] got;
    logic [7:0] d;
    mode = 2'b00;
    sck = 1'b0;
    pulse_clr();
    frame_begin();
    for (int k = 1; k <= 4; k++)
      xfer(32'(k), 8, got);
    pop_on_push = 1'b1;
    xfer(32'h05, 8, got);
    pop_on_push = 1'b0;
    n_cmp++;
    if (rx_level8 !== 3'd4) begin
      n_bad++;
      $display("FAIL full_pp_level: got %0d want 4", rx_level8);
    end
    frame_end();
    n_cmp++;
    if (overrun8 !== 1'b0) begin
      n_bad++;
      $display("FAIL full_pp_overrun: got %b want 0", overrun8);
    end
    for (int k = 2; k <= 5; k++) begin
      pop8(d);
      n_cmp++;
      if (d !== 8'(k)) begin
        n_bad++;
        $display("FAIL full_pp_data%0d: got %h want %h",
                 k, d, 8'(k));
      end
    end
  endtask

  initial begin
    tx_valid8 = 1'b0;
    tx_data8 = '0;
    rx_ready8 = 1'b0;
    tx_valid16 = 1'b0;
    tx_data16 = '0;
    rx_ready16 = 1'b0;
    rv_early = 1'b0;
    test_reset();
    test_mode0();
    test_back_to_back();
    test_overrun();
    test_underrun();
    test_abort();
    test_full_push_pop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
